// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped board I/O block: word addresses,
// sticky-flag position in the KEY word and the seven-segment glyph table.
package io_pkg;

  localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

  // Sticky press flags sit directly above the four debounced key levels.
  localparam int KEY_STICKY_LSB = 4;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}; entry n is SEG7[n].
  localparam logic [15:0][6:0] SEG7 = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
module seven_seg_decoder
  import io_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7[i_nibble];

endmodule

// File: rtl/io_bus_controller.sv
// Memory-mapped board I/O: registers processor writes onto HEX/LEDR/LEDG and
// returns synchronized switch state and debounced key state on reads with a
// single cycle of latency. Addresses outside the five I/O words are ignored.
module io_bus_controller
  import io_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [DBITS-1:0] ABUS,
  input  logic             WE,
  input  logic             RE,
  input  logic [DBITS-1:0] DBUS_IN,
  output logic [DBITS-1:0] DBUS_OUT,
  output logic             RD_VALID,
  output logic             IO_HIT,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Output and status registers
  logic [23:0]      r_hex;
  logic [9:0]       r_ledr;
  logic [7:0]       r_ledg;
  logic [3:0]       r_sticky;
  logic [DBITS-1:0] r_dbus_out;
  logic             r_rd_valid;

  // Input synchronizers
  logic [3:0] r_key_meta;
  logic [3:0] r_key_sync;
  logic [9:0] r_sw_meta;
  logic [9:0] r_sw_sync;

  // Address decode, read mux and debounce results
  logic             w_sel_hex;
  logic             w_sel_ledr;
  logic             w_sel_ledg;
  logic             w_sel_key;
  logic             w_sel_sw;
  logic             w_hit;
  logic [DBITS-1:0] w_rd_data;
  logic [3:0]       w_key_level;
  logic [3:0]       w_key_press;
  logic [3:0]       w_sticky_clr;
  logic [5:0][6:0]  w_hex_seg;
  logic             w_unused;

  // Full-word decode: the byte offset bits must match exactly.
  always_comb begin
    w_sel_hex  = (ABUS == DBITS'(ADDR_HEX));
    w_sel_ledr = (ABUS == DBITS'(ADDR_LEDR));
    w_sel_ledg = (ABUS == DBITS'(ADDR_LEDG));
    w_sel_key  = (ABUS == DBITS'(ADDR_KEY));
    w_sel_sw   = (ABUS == DBITS'(ADDR_SW));
    w_hit      = w_sel_hex | w_sel_ledr | w_sel_ledg | w_sel_key | w_sel_sw;
  end

  assign IO_HIT = w_hit;

  // Bring the asynchronous keys and switches into the clock domain (2 flops).
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_key_meta <= 4'hF;
      r_key_sync <= 4'hF;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_key_meta <= KEY;
      r_key_sync <= r_key_meta;
      r_sw_meta  <= SW;
      r_sw_sync  <= r_sw_meta;
    end
  end

  // Independent debouncer per key; the stable value is kept active-low.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;
      logic             w_accept;

      assign w_accept = (r_key_sync[gi] != r_stable) && (r_cnt == CNT_LAST);

      // Count cycles of disagreement; any agreement resets the count.
      always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
          r_cnt    <= '0;
          r_stable <= 1'b1;
        end else if (r_key_sync[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_stable <= r_key_sync[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_key_level[gi] = ~r_stable;
      // A press is the acceptance of a low synced level.
      assign w_key_press[gi] = w_accept & ~r_key_sync[gi];
    end
  endgenerate

  assign w_sticky_clr = (WE && w_sel_key) ? DBUS_IN[KEY_STICKY_LSB +: 4] : 4'b0;

  // Sticky flags: write-1-to-clear, with a same-cycle press taking priority.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~w_sticky_clr) | w_key_press;
    end
  end

  // Board output registers take the low bits of the write data.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_hex  <= '0;
      r_ledr <= '0;
      r_ledg <= '0;
    end else if (WE) begin
      if (w_sel_hex)  r_hex  <= DBUS_IN[23:0];
      if (w_sel_ledr) r_ledr <= DBUS_IN[9:0];
      if (w_sel_ledg) r_ledg <= DBUS_IN[7:0];
    end
  end

  // Read mux uses current register contents, so WE+RE returns the old value.
  always_comb begin
    w_rd_data = '0;
    if (w_sel_hex)  w_rd_data = DBITS'(r_hex);
    if (w_sel_ledr) w_rd_data = DBITS'(r_ledr);
    if (w_sel_ledg) w_rd_data = DBITS'(r_ledg);
    if (w_sel_key)  w_rd_data = DBITS'({r_sticky, w_key_level});
    if (w_sel_sw)   w_rd_data = DBITS'(r_sw_sync);
  end

  // Registered read response: one result per cycle, zero when no hit.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_dbus_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= RE & w_hit;
      r_dbus_out <= (RE & w_hit) ? w_rd_data : '0;
    end
  end

  assign DBUS_OUT = r_dbus_out;
  assign RD_VALID = r_rd_valid;
  assign LEDR     = r_ledr;
  assign LEDG     = r_ledg;

  generate
    for (gi = 0; gi < 6; gi++) begin : g_hex
      seven_seg_decoder u_dec (
        .i_nibble (r_hex[gi*4 +: 4]),
        .o_seg    (w_hex_seg[gi])
      );
    end
  endgenerate

  assign HEX0 = w_hex_seg[0];
  assign HEX1 = w_hex_seg[1];
  assign HEX2 = w_hex_seg[2];
  assign HEX3 = w_hex_seg[3];
  assign HEX4 = w_hex_seg[4];
  assign HEX5 = w_hex_seg[5];

  // Upper write-data bits are architecturally ignored.
  assign w_unused = ^DBUS_IN[DBITS-1:24];

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller with a short debounce window.
module tb_io_bus_controller;

  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] abus;
  logic        we;
  logic        re;
  logic [31:0] dbus_in;
  logic [31:0] dbus_out;
  logic        rd_valid;
  logic        io_hit;
  logic [3:0]  key;
  logic [9:0]  sw;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_bus_controller #(.DBITS(32), .DEBOUNCE_CYCLES(8)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .ABUS     (abus),
    .WE       (we),
    .RE       (re),
    .DBUS_IN  (dbus_in),
    .DBUS_OUT (dbus_out),
    .RD_VALID (rd_valid),
    .IO_HIT   (io_hit),
    .KEY      (key),
    .SW       (sw),
    .LEDR     (ledr),
    .LEDG     (ledg),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .HEX4     (hex4),
    .HEX5     (hex5)
  );

  typedef struct packed {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic        exp_valid;
    logic [31:0] exp_dbus;
    logic [9:0]  exp_ledr;
    logic [7:0]  exp_ledg;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    we = w;
    re = r;
    abus = a;
    dbus_in = d;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, a, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    $display("read  addr=%h data=%h valid=%b", a, dbus_out, rd_valid);
    check({name, "_valid"}, {31'b0, rd_valid}, 32'h1);
    check({name, "_data"}, dbus_out, exp);
  endtask

  task automatic check_hex(input string name, input logic [41:0] exp);
    check({name, "_hex0"}, {25'b0, hex0}, {25'b0, exp[6:0]});
    check({name, "_hex1"}, {25'b0, hex1}, {25'b0, exp[13:7]});
    check({name, "_hex2"}, {25'b0, hex2}, {25'b0, exp[20:14]});
    check({name, "_hex3"}, {25'b0, hex3}, {25'b0, exp[27:21]});
    check({name, "_hex4"}, {25'b0, hex4}, {25'b0, exp[34:28]});
    check({name, "_hex5"}, {25'b0, hex5}, {25'b0, exp[41:35]});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //             we    re    addr        wdata          hit   valid dbus           ledr    ledg
    vecs[0]  = '{1'b1, 1'b0, A_LEDR,      32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 10'h3FF, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, A_LEDR,      32'h00000000, 1'b1, 1'b1, 32'h000003FF, 10'h3FF, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,       32'h00000000, 1'b0, 1'b0, 32'h00000000, 10'h3FF, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, A_LEDG,      32'h00000011, 1'b1, 1'b0, 32'h00000000, 10'h3FF, 8'h11};
    vecs[4]  = '{1'b1, 1'b1, A_LEDG,      32'h0000005A, 1'b1, 1'b1, 32'h00000011, 10'h3FF, 8'h5A};
    vecs[5]  = '{1'b0, 1'b1, A_LEDG,      32'h00000000, 1'b1, 1'b1, 32'h0000005A, 10'h3FF, 8'h5A};
    vecs[6]  = '{1'b0, 1'b1, 32'h100,     32'h00000000, 1'b0, 1'b0, 32'h00000000, 10'h3FF, 8'h5A};
    vecs[7]  = '{1'b1, 1'b0, 32'h100,     32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 10'h3FF, 8'h5A};
    vecs[8]  = '{1'b1, 1'b0, 32'hF0000005, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 10'h3FF, 8'h5A};
    vecs[9]  = '{1'b1, 1'b0, A_SW,        32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 10'h3FF, 8'h5A};
    vecs[10] = '{1'b0, 1'b1, A_SW,        32'h00000000, 1'b1, 1'b1, 32'h00000000, 10'h3FF, 8'h5A};
    vecs[11] = '{1'b1, 1'b0, A_LEDR,      32'hFFFFF555, 1'b1, 1'b0, 32'h00000000, 10'h155, 8'h5A};
    vecs[12] = '{1'b0, 1'b1, A_LEDR,      32'h00000000, 1'b1, 1'b1, 32'h00000155, 10'h155, 8'h5A};
    vecs[13] = '{1'b0, 1'b1, A_LEDG,      32'h00000000, 1'b1, 1'b1, 32'h0000005A, 10'h155, 8'h5A};
    vecs[14] = '{1'b0, 1'b1, A_HEX,       32'h00000000, 1'b1, 1'b1, 32'h00ABCDEF, 10'h155, 8'h5A};
    vecs[15] = '{1'b1, 1'b0, A_LEDG,      32'hFFFFFF00, 1'b1, 1'b0, 32'h00000000, 10'h155, 8'h00};

    rst = 1'b1;
    key = 4'hF;
    sw  = 10'h0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    $display("reset released");
    check_hex("reset", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    check("reset_ledr", {22'b0, ledr}, 32'h0);
    check("reset_ledg", {24'b0, ledg}, 32'h0);
    check("reset_valid", {31'b0, rd_valid}, 32'h0);
    check("reset_dbus", dbus_out, 32'h0);
    bus_read("reset_key", A_KEY, 32'h0);

    // HEX write and decode
    bus_write(A_HEX, 32'h00ABCDEF);
    check_hex("hex_abcdef", {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});

    // Table-driven single-cycle transactions
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_hit", i), {31'b0, io_hit}, {31'b0, vecs[i].exp_hit});
      tick();
      $display("vec %0d: we=%b re=%b addr=%h wdata=%h -> dbus=%h valid=%b ledr=%h ledg=%h",
               i, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, dbus_out, rd_valid, ledr, ledg);
      check($sformatf("vec%0d_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d_dbus", i), dbus_out, vecs[i].exp_dbus);
      check($sformatf("vec%0d_ledr", i), {22'b0, ledr}, {22'b0, vecs[i].exp_ledr});
      check($sformatf("vec%0d_ledg", i), {24'b0, ledg}, {24'b0, vecs[i].exp_ledg});
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("idle_valid", {31'b0, rd_valid}, 32'h0);

    // Switch synchronization
    sw = 10'b1010101010;
    repeat (3) tick();
    bus_read("sw_read", A_SW, 32'h000002AA);

    // Stable press of KEY[1]
    key = 4'b1101;
    repeat (12) tick();
    bus_read("key_press", A_KEY, 32'h00000022);

    // Release: level drops, sticky remains
    key = 4'hF;
    repeat (12) tick();
    bus_read("key_release", A_KEY, 32'h00000020);

    // Short glitch is rejected
    key = 4'b1101;
    repeat (4) tick();
    key = 4'hF;
    repeat (12) tick();
    bus_read("key_glitch", A_KEY, 32'h00000020);

    // Clear sticky while held
    key = 4'b1101;
    repeat (12) tick();
    bus_read("key_held", A_KEY, 32'h00000022);
    bus_write(A_KEY, 32'h00000020);
    bus_read("key_clear", A_KEY, 32'h00000002);

    // Clear coinciding with a new stable press: the set wins
    key = 4'hF;
    repeat (12) tick();
    bus_read("key_rel2", A_KEY, 32'h00000000);
    key = 4'b1101;
    repeat (9) tick();
    bus_write(A_KEY, 32'h00000020);
    bus_read("key_set_wins", A_KEY, 32'h00000022);

    // Reset right after a read strobe drops the pending response
    key = 4'hF;
    drive(1'b0, 1'b1, A_LEDR, 32'h0);
    tick();
    check("prereset_valid", {31'b0, rd_valid}, 32'h1);
    check("prereset_dbus", dbus_out, 32'h00000155);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    $display("reset asserted after read: dbus=%h valid=%b", dbus_out, rd_valid);
    check("midreset_valid", {31'b0, rd_valid}, 32'h0);
    check("midreset_dbus", dbus_out, 32'h0);
    check("midreset_ledr", {22'b0, ledr}, 32'h0);
    check_hex("midreset", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    rst = 1'b0;
    tick();
    bus_read("postreset_key", A_KEY, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
